navibot_uart_cmd: RTL and testbench



---
 rtl/navibot_pkg.sv | 17 +
 rtl/uart_rx_8n1.sv | 72 +++++++
 rtl/navibot_uart_cmd.sv | 71 +++++++
 tb/tb_navibot_uart_cmd.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/navibot_pkg.sv
// navibot_pkg: command byte codes, RX state encoding and case folding shared by the UART command stage
package navibot_pkg;

    localparam logic [7:0] CMD_FWD   = 8'h46;
    localparam logic [7:0] CMD_LEFT  = 8'h4C;
    localparam logic [7:0] CMD_RIGHT = 8'h52;
    localparam logic [7:0] CMD_STOP  = 8'h53;
    localparam logic [7:0] CMD_FAST  = 8'h48;
    localparam logic [7:0] CMD_SLOW  = 8'h57;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 2-flop synchronised 8N1 receiver; rx_valid/frame_err pulse the cycle after the stop sample
module uart_rx_8n1 import navibot_pkg::*; #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    logic          s1, s2;
    rx_state_t     state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic          tick, shift, ok, bad;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= uart_rx;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = s2 ? IDLE : START;
            START:   if (tick) nxt = s2 ? IDLE : DATA;
            DATA:    if (shift && bitn == 3'd7) nxt = STOP;
            STOP:    if (tick) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // START times out at half a bit so every later sample lands mid-bit
    always_comb begin
        tick  = cnt == CW'(state == START ? HALF - 1 : CLKS_PER_BIT - 1);
        shift = state == DATA && tick;
        ok    = state == STOP && tick && s2;
        bad   = state == STOP && tick && !s2;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt       <= '0;
            bitn      <= 3'd0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            bitn      <= (state == IDLE) ? 3'd0 : (shift && bitn != 3'd7) ? bitn + 3'd1 : bitn;
            rx_byte   <= shift ? {s2, rx_byte[7:1]} : rx_byte;
            rx_valid  <= ok;
            frame_err <= bad;
        end
    end

endmodule

// File: rtl/navibot_uart_cmd.sv
// navibot_uart_cmd: decodes UART drive commands into registered motor/blinker levels with a silence watchdog
module navibot_uart_cmd import navibot_pkg::*; #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int WDT_MS = 500
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] led,
    output logic       l_mtr_ctrl,
    output logic       r_mtr_ctrl,
    output logic       l_led_en,
    output logic       r_led_en,
    output logic       slow0_fast1,
    output logic       frame_err,
    output logic       wdt_trip
);

    localparam int CPB     = CLK_HZ / BAUD;
    localparam int WDT_CYC = WDT_MS * (CLK_HZ / 1000);
    localparam int WW      = WDT_CYC > 1 ? $clog2(WDT_CYC + 1) : 1;

    logic [7:0]    rx_byte, u;
    logic          rx_valid;
    logic          is_f, is_l, is_r, is_s, is_h, is_w, mov, cmd, expire;
    logic [WW-1:0] wdt;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk_in    (clk_in),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // expiry is suppressed when a command lands on the same cycle, so the command wins
    always_comb begin
        u      = to_upper(rx_byte);
        is_f   = u == CMD_FWD;
        is_l   = u == CMD_LEFT;
        is_r   = u == CMD_RIGHT;
        is_s   = u == CMD_STOP;
        is_h   = u == CMD_FAST;
        is_w   = u == CMD_SLOW;
        mov    = is_f || is_l || is_r || is_s;
        cmd    = rx_valid && (mov || is_h || is_w);
        expire = WDT_CYC != 0 && !cmd && wdt == WW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            led                                          <= 8'h00;
            {l_mtr_ctrl, r_mtr_ctrl, l_led_en, r_led_en} <= 4'b0000;
            slow0_fast1                                  <= 1'b0;
            wdt                                          <= WW'(WDT_CYC);
            wdt_trip                                     <= 1'b0;
        end else begin
            led <= rx_valid ? rx_byte : led;
            if (rx_valid && mov)
                {l_mtr_ctrl, r_mtr_ctrl, l_led_en, r_led_en} <= is_f ? 4'b1100 : is_l ? 4'b0110 : is_r ? 4'b1001 : 4'b0000;
            else if (expire)
                {l_mtr_ctrl, r_mtr_ctrl, l_led_en, r_led_en} <= 4'b0000;
            slow0_fast1 <= (rx_valid && is_h) ? 1'b1 : (rx_valid && is_w) ? 1'b0 : slow0_fast1;
            wdt         <= cmd ? WW'(WDT_CYC) : (wdt != '0) ? wdt - 1'b1 : wdt;
            wdt_trip    <= expire;
        end
    end

endmodule

// File: tb/tb_navibot_uart_cmd.sv
// tb_navibot_uart_cmd: directed UART frames at 10 clks/bit with a 1000-cycle watchdog
module tb_navibot_uart_cmd;

    logic       clk_in = 1'b0;
    logic       rst, uart_rx;
    logic [7:0] led;
    logic       l_mtr_ctrl, r_mtr_ctrl, l_led_en, r_led_en, slow0_fast1, frame_err, wdt_trip;
    int         checks = 0, errors = 0;
    int         fe_cnt = 0, trip_cnt = 0;
    int         fe0, tr0;
    logic [7:0] rb;

    navibot_uart_cmd #(.CLK_HZ(1_000_000), .BAUD(100_000), .WDT_MS(1)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .led         (led),
        .l_mtr_ctrl  (l_mtr_ctrl),
        .r_mtr_ctrl  (r_mtr_ctrl),
        .l_led_en    (l_led_en),
        .r_led_en    (r_led_en),
        .slow0_fast1 (slow0_fast1),
        .frame_err   (frame_err),
        .wdt_trip    (wdt_trip)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_err) fe_cnt++;
        if (wdt_trip) trip_cnt++;
    end

    wire [3:0] mot = {l_mtr_ctrl, r_mtr_ctrl, l_led_en, r_led_en};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive_bits(input logic [7:0] b);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(10);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stp);
        drive_bits(b);
        uart_rx = stp;
        tick(10);
        uart_rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset_led", led, 8'h00);
        chk("reset_mot", mot, 4'b0000);
        chk("reset_fast", slow0_fast1, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_trip", wdt_trip, 1'b0);
        tick(5);

        // 'F' with exact latency: stop sample at cycle 98, outputs at 99
        drive_bits(8'h46);
        uart_rx = 1'b1;
        tick(8);
        chk("F_led_early", led, 8'h00);
        chk("F_mot_early", mot, 4'b0000);
        tick(1);
        chk("F_led", led, 8'h46);
        chk("F_mot", mot, 4'b1100);
        tick(1);

        send(8'h6C, 1'b1);
        chk("l_mot", mot, 4'b0110);
        chk("l_led", led, 8'h6C);
        send(8'h52, 1'b1);
        chk("R_mot", mot, 4'b1001);
        chk("R_led", led, 8'h52);

        send(8'h48, 1'b1);
        chk("H_fast", slow0_fast1, 1'b1);
        chk("H_mot", mot, 4'b1001);
        send(8'h77, 1'b1);
        chk("w_fast", slow0_fast1, 1'b0);
        chk("w_mot", mot, 4'b1001);
        chk("w_led", led, 8'h77);

        fe0 = fe_cnt;
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(30);
        chk("glitch_ferr", fe_cnt, fe0);
        chk("glitch_led", led, 8'h77);
        chk("glitch_mot", mot, 4'b1001);

        send(8'h53, 1'b0);
        tick(20);
        chk("badstop_ferr", fe_cnt, fe0 + 1);
        chk("badstop_led", led, 8'h77);
        chk("badstop_mot", mot, 4'b1001);

        // watchdog: expiry edge is 1000 cycles after the output update
        send(8'h68, 1'b1);
        chk("h_fast", slow0_fast1, 1'b1);
        send(8'h46, 1'b1);
        tr0 = trip_cnt;
        tick(998);
        chk("wdt_pre_mot", mot, 4'b1100);
        chk("wdt_pre_trip", wdt_trip, 1'b0);
        tick(1);
        chk("wdt_trip", wdt_trip, 1'b1);
        chk("wdt_mot", mot, 4'b0000);
        chk("wdt_fast_kept", slow0_fast1, 1'b1);
        tick(5000);
        chk("wdt_single", trip_cnt, tr0 + 1);
        chk("wdt_hold_mot", mot, 4'b0000);

        // second 'F' completes on the expiry cycle of the first
        send(8'h46, 1'b1);
        tr0 = trip_cnt;
        tick(900);
        send(8'h46, 1'b1);
        chk("race_mot", mot, 4'b1100);
        chk("race_notrip", trip_cnt, tr0);
        tick(998);
        chk("race_reload_mot", mot, 4'b1100);
        chk("race_reload_notrip", trip_cnt, tr0);
        tick(1);
        chk("race_reload_trip", wdt_trip, 1'b1);

        send(8'h4C, 1'b1);
        chk("L_mot", mot, 4'b0110);
        chk("L_led", led, 8'h4C);

        // reset in the middle of data bit 4
        fe0 = fe_cnt;
        rb = 8'h46;
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            uart_rx = rb[i];
            tick(10);
        end
        uart_rx = rb[4];
        tick(5);
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("midrst_led", led, 8'h00);
        chk("midrst_mot", mot, 4'b0000);
        chk("midrst_fast", slow0_fast1, 1'b0);
        tick(30);
        send(8'h52, 1'b1);
        chk("post_rst_mot", mot, 4'b1001);
        chk("post_rst_led", led, 8'h52);
        chk("post_rst_ferr", fe_cnt, fe0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
